// File: rtl/motor_pkg.sv
// Shared motor speed types: signed speed word, its magnitude limit and the
// per-channel ramp state used by the ramp, steering and motor control blocks.
package motor_pkg;

    typedef logic signed [10:0] speed_t;

    localparam speed_t SPEED_MAX = 11'sd1023;

    typedef enum logic [1:0] {
        SETTLED = 2'd0,
        RAMP    = 2'd1,
        DWELL   = 2'd2
    } ramp_st_t;

endpackage

// File: rtl/motor_ramp_if.sv
// Command/feedback bundle between the steering logic and the speed ramp.
interface motor_ramp_if;
    import motor_pkg::*;

    speed_t lft_tgt;
    speed_t rht_tgt;
    logic   tgt_vld;
    logic   estop;
    speed_t lft;
    speed_t rht;
    logic   at_tgt;

    modport master (
        output lft_tgt, rht_tgt, tgt_vld, estop,
        input  lft, rht, at_tgt
    );

    modport slave (
        input  lft_tgt, rht_tgt, tgt_vld, estop,
        output lft, rht, at_tgt
    );

endinterface

// File: rtl/ramp_chan.sv
// One slew-limited speed channel: target register, ramp FSM, zero-dwell counter
// and the registered output speed.
module ramp_chan
    import motor_pkg::*;
#(
    parameter int STEP      = 16,
    parameter int ZERO_HOLD = 8
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   tick,
    input  logic   estop,
    input  logic   tgt_vld,
    input  speed_t tgt_in,
    output speed_t cur,
    output logic   settle_nxt
);

    localparam int DW_W = $clog2(ZERO_HOLD + 1);
    localparam logic signed [11:0] STEP_S = 12'(STEP);

    ramp_st_t        st, st_nxt;
    speed_t          tgt, tgt_nxt, cur_nxt;
    speed_t          cap, toward_zero, toward_tgt;
    logic [DW_W-1:0] dwell, dwell_nxt, dwell_inc;
    logic            reversing;

    // -1024 has no positive mirror, so it is folded onto -1023
    function automatic speed_t sat_speed(input speed_t v);
        return (v < -SPEED_MAX) ? -SPEED_MAX : v;
    endfunction

    // One bounded step from 'from' toward 'dst', landing exactly on dst when close
    function automatic speed_t approach(input speed_t from, input speed_t dst);
        logic signed [11:0] diff, mag, nxt;
        diff = {dst[10], dst} - {from[10], from};
        mag  = (diff < 0) ? -diff : diff;
        if (mag <= STEP_S)
            nxt = {dst[10], dst};
        else if (diff < 0)
            nxt = {from[10], from} - STEP_S;
        else
            nxt = {from[10], from} + STEP_S;
        return nxt[10:0];
    endfunction

    assign cap         = sat_speed(tgt_in);
    assign toward_zero = approach(cur, '0);
    assign toward_tgt  = approach(cur, tgt);
    assign reversing   = (cur != '0) && ((tgt == '0) || (tgt[10] != cur[10]));
    assign dwell_inc   = dwell + 1'b1;
    assign settle_nxt  = (st_nxt == SETTLED);

    always_comb begin
        st_nxt    = st;
        cur_nxt   = cur;
        tgt_nxt   = tgt;
        dwell_nxt = dwell;
        if (estop) begin
            st_nxt    = SETTLED;
            cur_nxt   = '0;
            tgt_nxt   = '0;
            dwell_nxt = '0;
        end else begin
            if (tgt_vld)
                tgt_nxt = cap;
            case (st)
                SETTLED: begin
                    if ((tgt_vld && cap != cur) || (tick && tgt != cur))
                        st_nxt = RAMP;
                end
                RAMP: begin
                    if (tick) begin
                        if (reversing) begin
                            cur_nxt = toward_zero;
                            if (toward_zero == '0) begin
                                st_nxt    = (tgt != '0) ? DWELL : SETTLED;
                                dwell_nxt = '0;
                            end
                        end else begin
                            cur_nxt = toward_tgt;
                            if (toward_tgt == tgt)
                                st_nxt = SETTLED;
                        end
                    end
                end
                DWELL: begin
                    // a retarget here only changes where we head once the dwell ends
                    if (tick) begin
                        dwell_nxt = dwell_inc;
                        if (dwell_inc == DW_W'(ZERO_HOLD))
                            st_nxt = (tgt != '0) ? RAMP : SETTLED;
                    end
                end
                default: st_nxt = SETTLED;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st    <= SETTLED;
            cur   <= '0;
            tgt   <= '0;
            dwell <= '0;
        end else begin
            st    <= st_nxt;
            cur   <= cur_nxt;
            tgt   <= tgt_nxt;
            dwell <= dwell_nxt;
        end
    end

endmodule

// File: rtl/motor_ramp.sv
// Dual-channel slew-rate limiter in front of the PWM motor controller: shared tick
// prescaler, two independent ramp channels and the combined at-target flag.
module motor_ramp
    import motor_pkg::*;
#(
    parameter int TICK_DIV  = 1024,
    parameter int STEP      = 16,
    parameter int ZERO_HOLD = 8
) (
    input logic        clk,
    input logic        rst,
    motor_ramp_if.slave bus
);

    localparam int TC_W = $clog2(TICK_DIV);

    logic [TC_W-1:0] tick_cnt;
    logic            tick;
    speed_t          lft_cur, rht_cur;
    logic            lft_settle_nxt, rht_settle_nxt;
    logic            at_tgt_q;

    assign tick = (tick_cnt == TC_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    ramp_chan #(.STEP(STEP), .ZERO_HOLD(ZERO_HOLD)) u_lft (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .estop      (bus.estop),
        .tgt_vld    (bus.tgt_vld),
        .tgt_in     (bus.lft_tgt),
        .cur        (lft_cur),
        .settle_nxt (lft_settle_nxt)
    );

    ramp_chan #(.STEP(STEP), .ZERO_HOLD(ZERO_HOLD)) u_rht (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .estop      (bus.estop),
        .tgt_vld    (bus.tgt_vld),
        .tgt_in     (bus.rht_tgt),
        .cur        (rht_cur),
        .settle_nxt (rht_settle_nxt)
    );

    // built from next-state so at_tgt drops in the same cycle the channel leaves SETTLED
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            at_tgt_q <= 1'b1;
        else
            at_tgt_q <= lft_settle_nxt & rht_settle_nxt;
    end

    assign bus.lft    = lft_cur;
    assign bus.rht    = rht_cur;
    assign bus.at_tgt = at_tgt_q;

endmodule

// File: tb/tb_motor_ramp.sv
// Directed bench for motor_ramp with TICK_DIV=4, STEP=32, ZERO_HOLD=2.
module tb_motor_ramp;

    logic clk;
    logic rst;
    int   ph;
    int   n_chk  = 0;
    int   n_pass = 0;

    motor_ramp_if bus();

    motor_ramp #(.TICK_DIV(4), .STEP(32), .ZERO_HOLD(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // independent prescaler phase: ph==0 right after a tick edge
    always @(posedge clk or posedge rst) begin
        if (rst) ph <= 0;
        else     ph <= (ph == 3) ? 0 : ph + 1;
    end

    task automatic chk_val(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    endtask

    task automatic next_tick();
        int n;
        @(negedge clk);
        n = 1;
        while (ph != 0 && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (ph != 0) chk_val("tick_wait", ph, 0);
    endtask

    task automatic cap(input int l, input int r);
        @(negedge clk);
        bus.lft_tgt = 11'(l);
        bus.rht_tgt = 11'(r);
        bus.tgt_vld = 1'b1;
        @(negedge clk);
        bus.tgt_vld = 1'b0;
    endtask

    task automatic estop_pulse();
        @(negedge clk);
        bus.estop = 1'b1;
        @(negedge clk);
        bus.estop = 1'b0;
        next_tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v[9];
        int lmin, r0, last_from, bad;
        rst = 1'b1;
        bus.lft_tgt = '0;
        bus.rht_tgt = '0;
        bus.tgt_vld = 1'b0;
        bus.estop   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_val("rst_lft", bus.lft, 0);
        chk_val("rst_rht", bus.rht, 0);
        chk_val("rst_at_tgt", bus.at_tgt, 1);

        // 1: ramp up from zero
        cap(100, 0);
        chk_val("cap_at_tgt_low", bus.at_tgt, 0);
        v = '{32, 64, 96, 100, 0, 0, 0, 0, 0};
        for (int i = 0; i < 4; i++) begin
            next_tick();
            chk_val($sformatf("up_%0d", i), bus.lft, v[i]);
        end
        chk_val("up_rht", bus.rht, 0);
        chk_val("up_at_tgt", bus.at_tgt, 1);

        // 2: reversal through zero with dwell
        cap(-70, 0);
        v = '{68, 36, 4, 0, 0, 0, -32, -64, -70};
        for (int i = 0; i < 9; i++) begin
            next_tick();
            chk_val($sformatf("rev_%0d", i), bus.lft, v[i]);
            if (i == 3) chk_val("rev_dwell_at_tgt", bus.at_tgt, 0);
        end
        chk_val("rev_at_tgt", bus.at_tgt, 1);

        // 3: full-scale targets, -1024 clamp
        cap(-1024, 1023);
        lmin = 0;
        last_from = 0;
        for (int i = 0; i < 36; i++) begin
            r0 = bus.rht;
            next_tick();
            if (bus.lft < lmin) lmin = bus.lft;
            if (bus.rht != r0) last_from = r0;
        end
        chk_val("fs_lft_min", lmin, -1023);
        chk_val("fs_lft", bus.lft, -1023);
        chk_val("fs_rht", bus.rht, 1023);
        chk_val("fs_rht_last_from", last_from, 992);
        chk_val("fs_at_tgt", bus.at_tgt, 1);

        // 4: estop mid-ramp with a simultaneous capture
        estop_pulse();
        chk_val("clr_lft", bus.lft, 0);
        cap(100, 80);
        next_tick();
        next_tick();
        chk_val("es_pre_lft", bus.lft, 64);
        bus.estop   = 1'b1;
        bus.tgt_vld = 1'b1;
        bus.lft_tgt = 11'sd500;
        bus.rht_tgt = 11'sd500;
        @(negedge clk);
        bus.tgt_vld = 1'b0;
        chk_val("es_lft", bus.lft, 0);
        chk_val("es_rht", bus.rht, 0);
        chk_val("es_at_tgt", bus.at_tgt, 1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            bus.tgt_vld = (i == 7);
            @(negedge clk);
            if (bus.lft != 0 || bus.rht != 0 || bus.at_tgt != 1'b1) bad++;
        end
        bus.tgt_vld = 1'b0;
        chk_val("es_hold", bad, 0);
        bus.estop = 1'b0;
        next_tick();
        chk_val("es_rel_lft", bus.lft, 0);
        chk_val("es_rel_at_tgt", bus.at_tgt, 1);
        cap(50, 0);
        next_tick();
        chk_val("es_resume_0", bus.lft, 32);
        next_tick();
        chk_val("es_resume_1", bus.lft, 50);

        // 5: retarget mid-ramp, then retarget during dwell
        estop_pulse();
        cap(200, 0);
        next_tick();
        next_tick();
        chk_val("rt_pre", bus.lft, 64);
        cap(40, 0);
        next_tick();
        chk_val("rt_40", bus.lft, 40);
        chk_val("rt_40_at_tgt", bus.at_tgt, 1);
        cap(200, 0);
        for (int k = 1; k <= 5; k++) begin
            next_tick();
            chk_val($sformatf("rt_up_%0d", k), bus.lft, 40 + 32 * k);
        end
        cap(-50, 0);
        for (int k = 1; k <= 6; k++) begin
            next_tick();
            chk_val($sformatf("rt_dn_%0d", k), bus.lft, 200 - 32 * k);
        end
        next_tick();
        chk_val("rt_zero", bus.lft, 0);
        next_tick();
        chk_val("rt_dwell1", bus.lft, 0);
        cap(-100, 0);
        next_tick();
        chk_val("rt_dwell2", bus.lft, 0);
        next_tick();
        chk_val("rt_no_extend", bus.lft, -32);

        // 6: channel independence, then async reset mid-dwell
        estop_pulse();
        cap(64, 0);
        next_tick();
        next_tick();
        cap(-64, 128);
        next_tick();
        chk_val("ind_l0", bus.lft, 32);
        chk_val("ind_r0", bus.rht, 32);
        next_tick();
        chk_val("ind_l1", bus.lft, 0);
        chk_val("ind_r1", bus.rht, 64);
        next_tick();
        chk_val("ind_l2", bus.lft, 0);
        chk_val("ind_r2", bus.rht, 96);
        chk_val("ind_at_tgt", bus.at_tgt, 0);
        #2 rst = 1'b1;
        #1;
        chk_val("arst_lft", bus.lft, 0);
        chk_val("arst_rht", bus.rht, 0);
        chk_val("arst_at_tgt", bus.at_tgt, 1);
        #1 rst = 1'b0;
        next_tick();
        next_tick();
        chk_val("post_rst_lft", bus.lft, 0);
        chk_val("post_rst_rht", bus.rht, 0);
        chk_val("post_rst_at_tgt", bus.at_tgt, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
